parity_generator: RTL and testbench

PARITY_GENERATOR -- requirements
Module: parity_generator

---
 rtl/parity_pkg.sv | 19 +
 rtl/parity_generator_if.sv | 23 ++
 rtl/parity_generator.sv | 112 +++++++++++
 tb/tb_parity_generator.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity generator.
// Holds the frame FSM state encoding and the parity-sense selectors.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Bit-counter width; a 1-wide counter still needs one bit.
    function automatic int cnt_width(input int data_w);
        return (data_w <= 2) ? 1 : $clog2(data_w);
    endfunction

endpackage

// File: rtl/parity_generator_if.sv
// Word-in / serial-out bundle of the parity generator.
// master drives the word handshake; slave is the generator.
interface parity_generator_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              x_out;
    logic              busy;
    logic              par_bit;
    logic              done;

    modport master (
        output din, din_valid,
        input  din_ready, x_out, busy, par_bit, done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, x_out, busy, par_bit, done
    );
endinterface

// File: rtl/parity_generator.sv
// Serialises a DATA_W word LSB first plus one parity bit; first bit 1 cycle after accept.
// din_ready is state-only; PARITY_GEN_B2B_EN also opens it in PARITY for gapless frames.
module parity_generator
    import parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ODD    = PAR_EVEN
) (
    input  logic               clk,
    input  logic               rst,
    parity_generator_if.slave  bus
);

    localparam int              CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic            PAR_SEED = (ODD == PAR_ODD);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              acc;
    logic              acc_nxt;
    logic              x_q;
    logic              x_nxt;
    logic              live;
    logic              rdy;
    logic              accept;

    // live holds ready low for the first cycle out of reset.
`ifdef PARITY_GEN_B2B_EN
    assign rdy = live && ((state == IDLE) || (state == PARITY));
`else
    assign rdy = live && (state == IDLE);
`endif

    assign accept = rdy && bus.din_valid;

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        x_nxt     = 1'b0;

        unique case (state)
            IDLE: begin
                state_nxt = IDLE;
            end
            SHIFT: begin
                // cnt is the index of the bit currently on x_out.
                if (cnt == LAST_BIT) begin
                    state_nxt = PARITY;
                    x_nxt     = acc ^ PAR_SEED;
                end else begin
                    x_nxt     = shreg[0];
                    shreg_nxt = shreg >> 1;
                    acc_nxt   = acc ^ shreg[0];
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            PARITY: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Bit 0 goes straight to x_out, so the accumulator starts from it.
        if (accept) begin
            state_nxt = SHIFT;
            x_nxt     = bus.din[0];
            shreg_nxt = bus.din >> 1;
            acc_nxt   = bus.din[0];
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            acc   <= 1'b0;
            x_q   <= 1'b0;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            x_q   <= x_nxt;
            live  <= 1'b1;
        end
    end

    assign bus.din_ready = rdy;
    assign bus.x_out     = x_q;
    assign bus.busy      = (state != IDLE);
    assign bus.par_bit   = (state == PARITY);
    assign bus.done      = (state == PARITY);

    a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
        (state == SHIFT) |-> (cnt <= LAST_BIT));

    a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> (x_q == 1'b0));

endmodule

// File: tb/tb_parity_generator.sv
// Directed and random frames through even and odd parity generators sharing one stimulus.
module tb_parity_generator;
    import parity_pkg::*;

`ifdef PARITY_GEN_B2B_EN
    localparam logic RDY_IN_PAR = 1'b1;
`else
    localparam logic RDY_IN_PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    int         n_chk  = 0;
    int         n_fail = 0;

    parity_generator_if #(.DATA_W(8)) b0 ();
    parity_generator_if #(.DATA_W(8)) b1 ();

    assign b0.din       = din;
    assign b0.din_valid = din_valid;
    assign b1.din       = din;
    assign b1.din_valid = din_valid;

    parity_generator #(.DATA_W(8), .ODD(PAR_EVEN)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    parity_generator #(.DATA_W(8), .ODD(PAR_ODD)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered just after a falling edge with the DUTs idle and ready.
    task automatic frame(input logic [7:0] w, input logic pe, input logic po, input bit full);
        logic [8:0] f0;
        logic [8:0] f1;
        f0 = '0;
        f1 = '0;
        if (full) chk("ready_idle", 32'(b0.din_ready), 32'd1);
        din       = w;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            din   = 8'($urandom);
            f0[i] = b0.x_out;
            f1[i] = b1.x_out;
            if (full) begin
                chk("busy", 32'(b0.busy), 32'd1);
                chk("par_bit", 32'(b0.par_bit), 32'(i == 8));
                chk("done", 32'(b0.done), 32'(i == 8));
                chk("ready_frame", 32'(b0.din_ready), (i == 8) ? 32'(RDY_IN_PAR) : 32'd0);
            end
            @(negedge clk);
        end
        chk("frame_even", 32'(f0), 32'({pe, w}));
        chk("frame_odd", 32'(f1), 32'({po, w}));
        if (full) begin
            chk("idle_busy", 32'(b0.busy), 32'd0);
            chk("idle_x", 32'(b0.x_out), 32'd0);
        end
    endtask

    initial begin
        logic [19:0] xs;
        logic [19:0] bs;
        logic [7:0]  v;
        logic [7:0]  w;
        int          dcnt;

        // Reset, with a word offered during reset that must be dropped.
        rst       = 1'b1;
        din       = 8'hA5;
        din_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(b0.x_out), 32'd0);
        chk("rst_busy", 32'(b0.busy), 32'd0);
        chk("rst_par", 32'(b0.par_bit), 32'd0);
        chk("rst_done", 32'(b0.done), 32'd0);
        chk("rst_ready", 32'(b0.din_ready), 32'd0);
        rst       = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(b0.din_ready), 32'd1);
        chk("no_accept_in_rst", 32'(b0.busy), 32'd0);

        // Directed words: A5 has 4 ones, 07 has 3, 00 has none.
        frame(8'hA5, 1'b0, 1'b1, 1'b1);
        frame(8'h07, 1'b1, 1'b0, 1'b1);
        frame(8'h00, 1'b0, 1'b1, 1'b1);

        // Two words with din_valid held high.
        din       = 8'hFF;
        din_valid = 1'b1;
        @(negedge clk);
        din = 8'h01;
        for (int k = 0; k < 20; k++) begin
            xs[k] = b0.x_out;
            bs[k] = b0.busy;
            if (k == 10) din_valid = 1'b0;
            @(negedge clk);
        end
`ifdef PARITY_GEN_B2B_EN
        chk("b2b_x", 32'(xs), 32'h202FF);
        chk("b2b_busy", 32'(bs), 32'h3FFFF);
`else
        chk("gap_x", 32'(xs), 32'h404FF);
        chk("gap_busy", 32'(bs), 32'h7FDFF);
`endif

        // Abort 5A on its fourth data bit.
        v         = 8'h5A;
        din       = v;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("abort_bit", 32'(b0.x_out), 32'(v[k]));
            if (k < 3) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_x", 32'(b0.x_out), 32'd0);
        chk("abort_busy", 32'(b0.busy), 32'd0);
        chk("abort_par", 32'(b0.par_bit), 32'd0);
        chk("abort_done", 32'(b0.done), 32'd0);
        chk("abort_ready", 32'(b0.din_ready), 32'd0);
        rst  = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (b0.done || b1.done || b0.busy) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        frame(8'h3C, 1'b0, 1'b1, 1'b1);

        // Random words with din scrambled mid-frame.
        for (int n = 0; n < 1000; n++) begin
            w = 8'($urandom);
            frame(w, ^w, ~^w, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
